// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encodings and baud divisor table.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID        = 8;
  localparam int unsigned DIV_W      = 14;
  localparam int unsigned REF_CLK_HZ = 50_000_000;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  function automatic int unsigned baud_rate(logic [2:0] code);
    int unsigned rate;
    case (code)
      3'd0:    rate = 300;
      3'd1:    rate = 1200;
      3'd2:    rate = 4800;
      3'd3:    rate = 9600;
      3'd4:    rate = 19200;
      3'd5:    rate = 38400;
      3'd6:    rate = 57600;
      default: rate = 115200;
    endcase
    return rate;
  endfunction

  // Table holds the 16x divisors for a 50 MHz clock; other clocks get a rounded recompute.
  function automatic logic [DIV_W-1:0] baud_divisor(int unsigned clk_hz, logic [2:0] code);
    logic [DIV_W-1:0] div;
    int unsigned      rate;
    case (code)
      3'd0:    div = 14'd10417;
      3'd1:    div = 14'd2604;
      3'd2:    div = 14'd651;
      3'd3:    div = 14'd326;
      3'd4:    div = 14'd163;
      3'd5:    div = 14'd81;
      3'd6:    div = 14'd54;
      default: div = 14'd27;
    endcase
    if (clk_hz != REF_CLK_HZ) begin
      rate = baud_rate(code);
      div  = DIV_W'((clk_hz + (OVERSAMPLE / 2) * rate) / (OVERSAMPLE * rate));
    end
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: single-cycle pulse every D clocks for the selected baud code.
module uart_rx_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       tick
);

  logic [DIV_W-1:0] div_table [8];
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < 8; i++) begin : g_div
    assign div_table[i] = baud_divisor(CLK_HZ, 3'(i));
  end

  assign div = div_table[baud_select];

  // >= rather than == so a switch to a faster rate never strands the counter above D.
  always_comb begin
    tick  = (cnt_q >= div);
    cnt_d = tick ? 14'd1 : cnt_q + 14'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8E1 UART receiver: 2-flop input synchronizer, 16x oversampled mid-bit FSM, registered pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam logic [3:0] OsMid    = 4'(MID);
  localparam logic [3:0] OsLast   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BitsDone = 4'(DATA_BITS);

  logic [1:0] sync_q;
  logic       rx;
  logic [2:0] state_q, state_d;
  logic [3:0] os_q, os_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [2:0] baud_q, baud_d;
  logic [2:0] tick_baud;
  logic       tick;
  logic       sample;
  logic       boundary;
  logic [7:0] data_d;
  logic       valid_d, perror_d, ferror_d;

  assign rx = sync_q[1];

  // Live code while idle; the latched code for the whole frame once a start bit is seen.
  assign tick_baud = (state_q == StIdle) ? baud_select : baud_q;

  uart_rx_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .baud_select(tick_baud),
    .tick       (tick)
  );

  assign sample   = tick && (os_q == OsMid);
  assign boundary = tick && (os_q == OsLast);

  always_comb begin
    state_d   = state_q;
    os_d      = os_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    baud_d    = baud_q;
    data_d    = Rx_DATA;
    valid_d   = 1'b0;
    perror_d  = 1'b0;
    ferror_d  = 1'b0;

    if (tick && (state_q != StIdle) && (state_q != StBreak)) begin
      os_d = os_q + 4'd1;
    end

    case (state_q)
      StIdle: begin
        if (tick && !rx) begin
          state_d   = StStart;
          os_d      = '0;
          bit_cnt_d = '0;
          baud_d    = baud_select;
        end
      end
      StStart: begin
        if (sample && rx) begin
          state_d = StIdle;
          os_d    = '0;
        end else if (boundary) begin
          state_d = StData;
        end
      end
      StData: begin
        if (sample) begin
          shift_d   = {rx, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (boundary && (bit_cnt_q == BitsDone)) begin
          state_d = StParity;
        end
      end
      StParity: begin
        if (sample) begin
          parity_d = rx;
        end else if (boundary) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample) begin
          data_d = shift_q;
          os_d   = '0;
          // Framing error outranks parity; a low stop bit parks the FSM until the line recovers.
          if (!rx) begin
            ferror_d = 1'b1;
            state_d  = StBreak;
          end else begin
            perror_d = (parity_q != ^shift_q);
            valid_d  = (parity_q == ^shift_q);
            state_d  = StIdle;
          end
        end
      end
      StBreak: begin
        if (tick && rx) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      state_q   <= StIdle;
      os_q      <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      baud_q    <= '0;
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], RxD};
      state_q   <= state_d;
      os_q      <= os_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      baud_q    <= baud_d;
      Rx_DATA   <= data_d;
      Rx_VALID  <= valid_d;
      Rx_PERROR <= perror_d;
      Rx_FERROR <= ferror_d;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected pulses, a monitor pops them.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int D7  = 27;
  localparam int D5  = 81;
  localparam int BIT7 = 16 * D7;
  localparam int LAT_MIN = 10 * 16 * D7;
  localparam int LAT_MAX = 11 * 16 * D7 + D7;

  localparam logic [2:0] KValid  = 3'b001;
  localparam logic [2:0] KPerror = 3'b010;
  localparam logic [2:0] KFerror = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         t_start;
    bit         chk_lat;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] baud_select;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  uart_receiver #(
    .CLK_HZ(50_000_000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .RxD        (RxD),
    .Rx_DATA    (Rx_DATA),
    .Rx_VALID   (Rx_VALID),
    .Rx_PERROR  (Rx_PERROR),
    .Rx_FERROR  (Rx_FERROR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [2:0] got;
    int         lat;
    if (!reset && (Rx_VALID || Rx_PERROR || Rx_FERROR)) begin
      got = {Rx_FERROR, Rx_PERROR, Rx_VALID};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got flags(F,P,V)=%b data=%h, expected no pulse", got,
                 Rx_DATA);
      end else begin
        e = sb.pop_front();
        if (got !== e.kind || Rx_DATA !== e.data) begin
          n_fail++;
          $display("FAIL pulse: got flags(F,P,V)=%b data=%h, expected flags=%b data=%h", got,
                   Rx_DATA, e.kind, e.data);
        end
        if (e.chk_lat) begin
          lat = cyc - e.t_start;
          n_checks++;
          if (lat < LAT_MIN || lat > LAT_MAX) begin
            n_fail++;
            $display("FAIL latency: got %0d clocks, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input logic [7:0] data, input bit lat);
    exp_t e;
    e.kind    = kind;
    e.data    = data;
    e.t_start = cyc;
    e.chk_lat = lat;
    sb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected pulses never seen, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int d);
    logic [10:0] bits;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      RxD = bits[i];
      repeat (16 * d) @(negedge clk);
    end
  endtask

  task automatic check_tick_period(input logic [2:0] code, input int d);
    int n;
    bit seen;
    baud_select = code;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2 * d + 4) begin
      @(negedge clk);
      n++;
      seen = dut.u_tick.tick;
    end
    n = 0;
    if (seen) begin
      seen = 1'b0;
      while (!seen && n < 2 * d + 4) begin
        @(negedge clk);
        n++;
        seen = dut.u_tick.tick;
      end
    end
    n_checks++;
    if (!seen || n != d) begin
      n_fail++;
      $display("FAIL tick_period code %0d: got %0d clocks (seen=%0b), expected %0d", code, n,
               seen, d);
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    RxD         = 1'b1;
    baud_select = 3'd7;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(Rx_DATA), 32'h00);
    check("reset_flags", 32'({Rx_FERROR, Rx_PERROR, Rx_VALID}), 32'h0);
    check("reset_state", 32'(dut.state_q), 32'(StIdle));
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Divisor table, line idle
    check_tick_period(3'd1, 2604);
    check_tick_period(3'd2, 651);
    check_tick_period(3'd3, 326);
    check_tick_period(3'd4, 163);
    check_tick_period(3'd5, 81);
    check_tick_period(3'd6, 54);
    check_tick_period(3'd7, 27);
    repeat (BIT7) @(negedge clk);

    // Good frame, even parity of A5 is 0
    expect_pulse(KValid, 8'hA5, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1, D7);
    check_drained("frame_a5");

    // 01 has odd weight, so parity 0 is wrong
    expect_pulse(KPerror, 8'h01, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1, D7);
    check_drained("frame_01_perror");

    // Low stop bit then line held low: one framing error, FSM parked in BREAK
    expect_pulse(KFerror, 8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, D7);
    repeat (2 * BIT7) @(negedge clk);
    check_drained("frame_3c_ferror");
    check("break_state", 32'(dut.state_q), 32'(StBreak));
    RxD = 1'b1;
    repeat (BIT7) @(negedge clk);
    check("break_exit", 32'(dut.state_q), 32'(StIdle));
    expect_pulse(KValid, 8'h55, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, D7);
    check_drained("frame_55");

    // Start-bit glitch of 5 ticks is rejected; Rx_DATA holds last byte
    RxD = 1'b0;
    repeat (5 * D7) @(negedge clk);
    RxD = 1'b1;
    repeat (20 * D7) @(negedge clk);
    check("glitch_state", 32'(dut.state_q), 32'(StIdle));
    check("glitch_hold_data", 32'(Rx_DATA), 32'h55);

    // Reset after start + 4 data bits of FF
    RxD = 1'b0;
    repeat (BIT7) @(negedge clk);
    RxD = 1'b1;
    repeat (4 * BIT7) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_data", 32'(Rx_DATA), 32'h00);
    check("midreset_state", 32'(dut.state_q), 32'(StIdle));
    reset = 1'b0;
    repeat (2 * BIT7) @(negedge clk);
    expect_pulse(KValid, 8'h12, 1'b0);
    send_frame(8'h12, 1'b0, 1'b1, D7);
    check_drained("frame_12_after_reset");

    // Back-to-back at code 5; code flips to 3 mid-frame and back before the stop bit
    baud_select = 3'd5;
    repeat (16 * D5) @(negedge clk);
    expect_pulse(KValid, 8'h00, 1'b0);
    expect_pulse(KValid, 8'hFF, 1'b0);
    fork
      send_frame(8'h00, 1'b0, 1'b1, D5);
      begin
        repeat (3 * 16 * D5) @(negedge clk);
        baud_select = 3'd3;
        repeat (6 * 16 * D5) @(negedge clk);
        baud_select = 3'd5;
      end
    join
    send_frame(8'hFF, 1'b0, 1'b1, D5);
    RxD = 1'b1;
    repeat (16 * D5) @(negedge clk);
    check_drained("back_to_back");
    check("final_data", 32'(Rx_DATA), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
